// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the UART-to-JTAG bridge: frame constants,
// instruction codes, header field positions and the parser state type.
package jtag_bridge_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [3:0] INSTR_SHIFT_IR = 4'h0;
    localparam logic [3:0] INSTR_SHIFT_DR = 4'h1;

    // Header byte layout: {instr, len}
    localparam int HDR_INSTR_MSB = 7;
    localparam int HDR_INSTR_LSB = 4;
    localparam int HDR_LEN_MSB   = 3;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_PAD,
        ST_PUSH_CMD
    } parser_state_e;

    // Only the two shift instructions are understood by the engine.
    function automatic logic instr_supported(input logic [3:0] instr);
        return (instr == INSTR_SHIFT_IR) || (instr == INSTR_SHIFT_DR);
    endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Inter-byte idle counter. Counts enabled cycles without a clear and
// pulses expire_o on the cycle the idle count reaches TIMEOUT_CYCLES.
// A clear in the same cycle suppresses the expiry.
module byte_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next idle count: restart on byte, when disabled, or after expiring.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || !enable_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // Idle count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART byte stream to command/payload FIFO writer. Frames are
// SYNC, {instr,len}, len payload bytes. FIFO space is checked at header
// time so a command is only ever written after its complete payload.
module uart_cmd_parser
    import jtag_bridge_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         ADDR_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  cmd_full,
    output logic                  cmd_wr_en,
    output logic [3:0]            cmd_instr,
    output logic [3:0]            cmd_len,
    input  logic [ADDR_WIDTH:0]   pay_space,
    output logic                  pay_wr_en,
    output logic [7:0]            pay_data,
    output logic                  busy,
    output logic                  err_pulse,
    output logic [7:0]            drop_cnt
);

    parser_state_e state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] instr_q, instr_d;
    logic [3:0] len_q, len_d;
    logic       pay_wr_en_q, pay_wr_en_d;
    logic [7:0] pay_data_q, pay_data_d;
    logic       cmd_wr_en_q, cmd_wr_en_d;
    logic [3:0] cmd_instr_q, cmd_instr_d;
    logic [3:0] cmd_len_q, cmd_len_d;
    logic       err_q, err_d;
    logic [7:0] drop_q, drop_d;
    logic       busy_q, busy_d;

    logic       tmo_enable;
    logic       tmo_expire;
    logic [3:0] hdr_instr;
    logic [3:0] hdr_len;
    logic       rx_sync;

    assign hdr_instr  = rx_data[HDR_INSTR_MSB:HDR_INSTR_LSB];
    assign hdr_len    = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign rx_sync    = rx_valid && (rx_data == SYNC_BYTE);
    assign tmo_enable = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);

    byte_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (rx_valid),
        .enable_i (tmo_enable),
        .expire_o (tmo_expire)
    );

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        instr_d     = instr_q;
        len_d       = len_q;
        pay_wr_en_d = 1'b0;
        pay_data_d  = pay_data_q;
        cmd_wr_en_d = 1'b0;
        cmd_instr_d = cmd_instr_q;
        cmd_len_d   = cmd_len_q;
        err_d       = 1'b0;
        drop_d      = drop_q;

        case (state_q)
            ST_SYNC: begin
                if (rx_sync) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    if ((hdr_len == 4'd0) || !instr_supported(hdr_instr)) begin
                        err_d   = 1'b1;
                        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        state_d = ST_SYNC;
                    end else if (cmd_full || (pay_space < (ADDR_WIDTH+1)'(hdr_len))) begin
                        // No room: swallow the payload bytes without pushing.
                        err_d   = 1'b1;
                        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        rem_d   = hdr_len;
                        state_d = ST_DRAIN;
                    end else begin
                        instr_d = hdr_instr;
                        len_d   = hdr_len;
                        rem_d   = hdr_len;
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    pay_wr_en_d = 1'b1;
                    pay_data_d  = rx_data;
                    rem_d       = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_PUSH_CMD;
                    end
                end else if (tmo_expire) begin
                    // Space is already promised, so finish the frame with zeros.
                    err_d   = 1'b1;
                    state_d = ST_PAD;
                end
            end
            ST_DRAIN: begin
                if (rx_valid) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_SYNC;
                    end
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_PAD: begin
                pay_wr_en_d = 1'b1;
                pay_data_d  = 8'h00;
                rem_d       = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = ST_PUSH_CMD;
                end
            end
            ST_PUSH_CMD: begin
                cmd_wr_en_d = 1'b1;
                cmd_instr_d = instr_q;
                cmd_len_d   = len_q;
                // A SYNC arriving right now already starts the next frame.
                state_d     = rx_sync ? ST_HDR : ST_SYNC;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        busy_d = (state_d != ST_SYNC);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            rem_q       <= 4'd0;
            instr_q     <= 4'd0;
            len_q       <= 4'd0;
            pay_wr_en_q <= 1'b0;
            pay_data_q  <= 8'h00;
            cmd_wr_en_q <= 1'b0;
            cmd_instr_q <= 4'd0;
            cmd_len_q   <= 4'd0;
            err_q       <= 1'b0;
            drop_q      <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            instr_q     <= instr_d;
            len_q       <= len_d;
            pay_wr_en_q <= pay_wr_en_d;
            pay_data_q  <= pay_data_d;
            cmd_wr_en_q <= cmd_wr_en_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_len_q   <= cmd_len_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign pay_wr_en = pay_wr_en_q;
    assign pay_data  = pay_data_q;
    assign cmd_wr_en = cmd_wr_en_q;
    assign cmd_instr = cmd_instr_q;
    assign cmd_len   = cmd_len_q;
    assign err_pulse = err_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with literal expectations,
// a saturation run, then randomized frames against a frame-level model.
module tb_uart_cmd_parser;

    localparam int TMO = 50;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_full = 1'b0;
    logic [10:0] pay_space = 11'd16;
    logic        cmd_wr_en;
    logic [3:0]  cmd_instr;
    logic [3:0]  cmd_len;
    logic        pay_wr_en;
    logic [7:0]  pay_data;
    logic        busy;
    logic        err_pulse;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Log of what the DUT actually wrote, used by the directed checks.
    logic [7:0] dut_pay_q[$];
    logic [7:0] dut_cmd_q[$];
    int         dut_err_n = 0;

    uart_cmd_parser #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .ADDR_WIDTH     (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cmd_full  (cmd_full),
        .cmd_wr_en (cmd_wr_en),
        .cmd_instr (cmd_instr),
        .cmd_len   (cmd_len),
        .pay_space (pay_space),
        .pay_wr_en (pay_wr_en),
        .pay_data  (pay_data),
        .busy      (busy),
        .err_pulse (err_pulse),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // The model tracks what the sender still owes: a header, some bytes
    // to keep or discard, zero padding owed, or a command to announce.
    bit         m_hdr, m_keep, m_cmd_pend;
    int         m_want, m_pad, m_idle, m_drop;
    logic [3:0] m_instr, m_len;
    logic       e_pay, e_cmd, e_err, e_busy;
    logic [7:0] e_data;
    logic [3:0] e_instr, e_len;

    task automatic model_reset();
        m_hdr = 0; m_keep = 0; m_cmd_pend = 0;
        m_want = 0; m_pad = 0; m_idle = 0; m_drop = 0;
        m_instr = 0; m_len = 0;
        e_pay = 0; e_cmd = 0; e_err = 0; e_busy = 0;
        e_data = 0; e_instr = 0; e_len = 0;
    endtask

    task automatic model_reject();
        e_err = 1;
        if (m_drop < 255) m_drop++;
    endtask

    task automatic model_step();
        int ins, ln;
        e_pay = 0; e_cmd = 0; e_err = 0;
        if (m_cmd_pend) begin
            e_cmd = 1; e_instr = m_instr; e_len = m_len;
            m_cmd_pend = 0;
            m_hdr = rx_valid && (rx_data == SYNC);
            m_idle = 0;
        end else if (m_pad > 0) begin
            e_pay = 1; e_data = 8'h00;
            m_pad--;
            if (m_pad == 0) m_cmd_pend = 1;
        end else if (m_hdr) begin
            if (rx_valid) begin
                m_idle = 0; m_hdr = 0;
                ins = int'(rx_data) / 16;
                ln  = int'(rx_data) % 16;
                if (ln == 0 || ins > 1) begin
                    model_reject();
                end else if (cmd_full || int'(pay_space) < ln) begin
                    model_reject();
                    m_want = ln; m_keep = 0;
                end else begin
                    m_want = ln; m_keep = 1;
                    m_instr = 4'(ins); m_len = 4'(ln);
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_idle = 0; m_hdr = 0; e_err = 1;
                end
            end
        end else if (m_want > 0) begin
            if (rx_valid) begin
                m_idle = 0;
                if (m_keep) begin
                    e_pay = 1; e_data = rx_data;
                end
                m_want--;
                if (m_want == 0 && m_keep) m_cmd_pend = 1;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_idle = 0; e_err = 1;
                    if (m_keep) m_pad = m_want;
                    m_want = 0;
                end
            end
        end else begin
            if (rx_valid && rx_data == SYNC) begin
                m_hdr = 1; m_idle = 0;
            end
        end
        e_busy = m_hdr || (m_want > 0) || (m_pad > 0) || m_cmd_pend;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle on the falling edge and log DUT writes.
    initial begin
        forever begin
            @(negedge clk);
            if (pay_wr_en === 1'b1) dut_pay_q.push_back(pay_data);
            if (cmd_wr_en === 1'b1) dut_cmd_q.push_back({cmd_instr, cmd_len});
            if (err_pulse === 1'b1) dut_err_n++;
            if (cmp_on) begin
                chk("pay_wr_en", 32'(pay_wr_en), 32'(e_pay));
                if (e_pay) chk("pay_data", 32'(pay_data), 32'(e_data));
                chk("cmd_wr_en", 32'(cmd_wr_en), 32'(e_cmd));
                if (e_cmd) begin
                    chk("cmd_instr", 32'(cmd_instr), 32'(e_instr));
                    chk("cmd_len", 32'(cmd_len), 32'(e_len));
                end
                chk("busy", 32'(busy), 32'(e_busy));
                chk("err_pulse", 32'(err_pulse), 32'(e_err));
                chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic clear_logs();
        dut_pay_q.delete();
        dut_cmd_q.delete();
        dut_err_n = 0;
    endtask

    // Expected bytes packed first-at-MSB: n bytes in exp[8*n-1:0].
    task automatic check_log(input string nm, input bit is_cmd, input int n, input logic [31:0] exp);
        int sz;
        sz = is_cmd ? dut_cmd_q.size() : dut_pay_q.size();
        chk({nm, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] want;
            logic [7:0] got;
            want = exp[8*(n-1-i) +: 8];
            got  = 8'hXX;
            if (i < sz) got = is_cmd ? dut_cmd_q[i] : dut_pay_q[i];
            chk(nm, 32'(got), 32'(want));
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pay_wr_en", 32'(pay_wr_en), 32'd0);
        chk("rst_cmd_wr_en", 32'(cmd_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_cmd_instr", 32'(cmd_instr), 32'd0);
        chk("rst_cmd_len", 32'(cmd_len), 32'd0);
        chk("rst_pay_data", 32'(pay_data), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        idle(2);
        pulse_reset();
        cmp_on = 1'b1;
        idle(2);

        // Valid Shift-DR frame with two payload bytes.
        clear_logs();
        send(8'hA5); send(8'h12); send(8'hDE); send(8'hAD);
        idle(3);
        check_log("t1_pay", 0, 2, 32'h0000DEAD);
        check_log("t1_cmd", 1, 1, 32'h00000012);
        chk("t1_drop", 32'(drop_cnt), 32'd0);
        chk("t1_err", 32'(dut_err_n), 32'd0);

        // Not enough payload space: frame drained, then a good frame.
        clear_logs();
        pay_space = 11'd2;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        idle(3);
        pay_space = 11'd16;
        check_log("t2_pay", 0, 0, 32'h0);
        check_log("t2_cmd", 1, 0, 32'h0);
        chk("t2_err", 32'(dut_err_n), 32'd1);
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        clear_logs();
        send(8'hA5); send(8'h01); send(8'h55);
        idle(3);
        check_log("t2b_pay", 0, 1, 32'h00000055);
        check_log("t2b_cmd", 1, 1, 32'h00000001);

        // Bad instruction and zero length rejected at the header.
        clear_logs();
        send(8'hA5); send(8'h20);
        chk("t3_busy_after_bad_instr", 32'(busy), 32'd0);
        send(8'hA5); send(8'h00);
        chk("t3_busy_after_zero_len", 32'(busy), 32'd0);
        idle(2);
        chk("t3_drop", 32'(drop_cnt), 32'd3);
        chk("t3_err", 32'(dut_err_n), 32'd2);
        check_log("t3_pay", 0, 0, 32'h0);

        // Payload timeout pads with zeros and still pushes the command.
        clear_logs();
        send(8'hA5); send(8'h04); send(8'h01);
        idle(TMO + 20);
        check_log("t4_pay", 0, 4, 32'h01000000);
        check_log("t4_cmd", 1, 1, 32'h00000004);
        chk("t4_err", 32'(dut_err_n), 32'd1);
        chk("t4_drop", 32'(drop_cnt), 32'd3);

        // Reset in the middle of a payload discards the frame.
        send(8'hA5); send(8'h0F); send(8'h01); send(8'h02); send(8'h03);
        pulse_reset();
        clear_logs();
        idle(20);
        check_log("t5_cmd", 1, 0, 32'h0);
        check_log("t5_pay", 0, 0, 32'h0);
        send(8'hA5); send(8'h01); send(8'h7E);
        idle(3);
        check_log("t5b_pay", 0, 1, 32'h0000007E);
        check_log("t5b_cmd", 1, 1, 32'h00000001);

        // Junk before a frame, all bytes back to back.
        clear_logs();
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h11); send(8'h5A);
        idle(3);
        check_log("t6_pay", 0, 1, 32'h0000005A);
        check_log("t6_cmd", 1, 1, 32'h00000011);

        // Saturation of the drop counter.
        for (int i = 0; i < 260; i++) begin
            send(8'hA5); send(8'h20);
        end
        idle(2);
        chk("sat_drop", 32'(drop_cnt), 32'd255);

        // Randomized frames against the model.
        pulse_reset();
        idle(2);
        for (int f = 0; f < 300; f++) begin
            int nj, ins, ln;
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) send(8'($urandom_range(0, 255)));
            cmd_full  = ($urandom_range(0, 9) == 0);
            pay_space = 11'($urandom_range(0, 20));
            ins = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 15) : $urandom_range(0, 1);
            ln  = $urandom_range(0, 15);
            send(SYNC);
            if ($urandom_range(0, 29) == 0) idle(TMO + 3);
            send(8'((ins << 4) | ln));
            for (int k = 0; k < ln; k++) begin
                if ($urandom_range(0, 29) == 0) idle(TMO + 5);
                else idle($urandom_range(0, 2));
                send(8'($urandom_range(0, 255)));
            end
            idle($urandom_range(0, 4));
        end
        idle(TMO + 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Upstream stage of the JTAG engine. It converts the raw UART RX byte stream into command FIFO entries ({instr, len}) and payload FIFO bytes.
- Frame format: SYNC byte 0xA5, then header byte {instr[7:4], len[3:0]}, then len payload bytes.
- Space is reserved at header time, so the engine never sees a command without its full payload.
- The command entry is pushed only after the last payload byte has been pushed.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum clk cycles between bytes inside a frame.
- ADDR_WIDTH, 10, payload FIFO address width; pay_space is ADDR_WIDTH+1 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  single-cycle strobe; one UART byte received; no backpressure.
- rx_data  in  8  received byte, valid with rx_valid.
- cmd_full  in  1  command FIFO full.
- cmd_wr_en  out  1  command FIFO write strobe.
- cmd_instr  out  4  instruction ID (0 = Shift-IR, 1 = Shift-DR).
- cmd_len  out  4  payload byte count, 1..15.
- pay_space  in  ADDR_WIDTH+1  free entries in payload FIFO.
- pay_wr_en  out  1  payload FIFO write strobe.
- pay_data  out  8  payload byte.
- busy  out  1  high in any state other than SYNC.
- err_pulse  out  1  one-cycle pulse on any rejected or timed-out frame.
- drop_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low.
- Reset values: all strobes 0; cmd_instr, cmd_len and pay_data 0; busy 0; drop_cnt 0; state SYNC; internal counters 0. Reset mid-frame discards the frame and pushes nothing further.
- All outputs are registered. pay_wr_en/pay_data follow the accepted rx_valid by exactly 1 cycle. cmd_wr_en follows the last payload write by 1 cycle.
- SYNC: wait for rx_valid with rx_data == SYNC_BYTE, then go to HDR. Other bytes are ignored silently.
- HDR, on rx_valid, in priority order:
  - len == 0 or instr > 1: reject, go to SYNC (no bytes to drain).
  - cmd_full or pay_space < len: reject, load rem = len, go to DRAIN.
  - Otherwise latch instr/len, load rem = len, go to PAYLOAD.
- PAYLOAD: each rx_valid pushes the byte and decrements rem. When rem reaches 0, go to PUSH_CMD.
- PUSH_CMD: assert cmd_wr_en for 1 cycle with the latched instr/len, then go to SYNC. No full check is needed (space was reserved).
- DRAIN: each rx_valid decrements rem with no push. At 0, go to SYNC. A SYNC_BYTE value inside DRAIN is treated as data.
- Timeout: an idle counter resets on every rx_valid and runs in HDR, PAYLOAD and DRAIN. On reaching TIMEOUT_CYCLES:
  - HDR or DRAIN: go to SYNC and pulse err_pulse.
  - PAYLOAD: go to PAD and pulse err_pulse.
- PAD: push 8'h00 once per cycle until rem = 0, then go to PUSH_CMD. Bytes arriving on rx_valid during PAD are ignored.
- Reject accounting: every rejection (HDR reject) asserts err_pulse and increments drop_cnt. Timeouts assert err_pulse only. drop_cnt saturates at 255 (no wrap).
- Simultaneous events: when rx_valid and the timeout threshold coincide, rx_valid wins and the counter resets.
- Throughput: back-to-back rx_valid every cycle must be accepted in all states. PUSH_CMD lasts 1 cycle; a SYNC byte arriving during PUSH_CMD is recognised.

Decomposition:
- Shared package jtag_bridge_pkg holds:
  - SYNC_BYTE default.
  - instr codes INSTR_SHIFT_IR = 4'h0 and INSTR_SHIFT_DR = 4'h1.
  - the parser state enum (SYNC, HDR, PAYLOAD, DRAIN, PAD, PUSH_CMD).
  - the header field slice positions.
- One sub-module, byte_timeout_counter: clear/enable inputs, expire pulse output, parameter TIMEOUT_CYCLES.

Test Plan:
- Bytes A5, 12, DE, AD with pay_space = 16 -> pay_wr_en twice (DE, then AD), then cmd_wr_en with instr = 1, len = 2; drop_cnt = 0.
- Bytes A5, 03, 11, 22, 33 with pay_space = 2 -> no pushes; err_pulse once; drop_cnt = 1; a following valid frame A5, 01, 55 is accepted normally.
- Bytes A5, 20 (instr 2) and A5, 00 (len 0) -> each rejected at header, no pushes; drop_cnt increments by 1 each; parser returns to SYNC immediately.
- Bytes A5, 04, 01, then silence for TIMEOUT_CYCLES (set to 50) -> pushes 01, 00, 00, 00, then cmd {0, 4}; err_pulse once; drop_cnt unchanged.
- rst_n low for 1 cycle mid-PAYLOAD of A5, 0F, ... -> all strobes 0, busy 0, no cmd pushed; next frame A5, 01, 7E gives pay 7E then cmd {0, 1}.
- Junk bytes 00, FF before A5, 11, 5A delivered on back-to-back cycles -> junk ignored; pay 5A lands 1 cycle after its rx_valid; cmd {1, 1} 1 cycle later.
